// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with forwarding, ALU decode and operand select
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic              id_stall,
  input  logic              id_flush,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_dst_addr,
  input  logic              id_reg_write,
  input  logic [15:0]       id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [5:0]        id_funct,
  input  logic [2:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dst_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dst_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] alu_data_a,
  output logic [DATA_W-1:0] alu_data_b,
  output logic [3:0]        alu_operation,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic [REG_AW-1:0] ex_dst_addr,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_illegal
);

  localparam logic [2:0] OP_RTYPE = 3'b010;

  logic              r_valid;
  logic              r_reg_write;
  logic [REG_AW-1:0] r_dst_addr;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [15:0]       r_imm;
  logic [4:0]        r_shamt;
  logic [5:0]        r_funct;
  logic [2:0]        r_alu_op;
  logic              r_alu_src;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_dst_addr  <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_shamt     <= '0;
      r_funct     <= '0;
      r_alu_op    <= '0;
      r_alu_src   <= 1'b0;
    end else if (id_flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_dst_addr  <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_shamt     <= '0;
      r_funct     <= '0;
      r_alu_op    <= '0;
      r_alu_src   <= 1'b0;
    end else if (!id_stall) begin
      r_valid     <= id_valid;
      r_reg_write <= id_reg_write;
      r_dst_addr  <= id_dst_addr;
      r_rs_addr   <= id_rs_addr;
      r_rt_addr   <= id_rt_addr;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_imm       <= id_imm;
      r_shamt     <= id_shamt;
      r_funct     <= id_funct;
      r_alu_op    <= id_alu_op;
      r_alu_src   <= id_alu_src;
    end
  end

  // MEM is the younger producer, so it wins over WB; register 0 is hardwired.
  logic              w_mem_rs_hit;
  logic              w_wb_rs_hit;
  logic              w_mem_rt_hit;
  logic              w_wb_rt_hit;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  assign w_mem_rs_hit = mem_reg_write && (mem_dst_addr != '0) && (mem_dst_addr == r_rs_addr);
  assign w_wb_rs_hit  = wb_reg_write  && (wb_dst_addr  != '0) && (wb_dst_addr  == r_rs_addr);
  assign w_mem_rt_hit = mem_reg_write && (mem_dst_addr != '0) && (mem_dst_addr == r_rt_addr);
  assign w_wb_rt_hit  = wb_reg_write  && (wb_dst_addr  != '0) && (wb_dst_addr  == r_rt_addr);

  assign w_fwd_rs = w_mem_rs_hit ? mem_result : (w_wb_rs_hit ? wb_result : r_rs_data);
  assign w_fwd_rt = w_mem_rt_hit ? mem_result : (w_wb_rt_hit ? wb_result : r_rt_data);

  logic              w_zero_ext;
  logic [DATA_W-1:0] w_ext_imm;

  assign w_zero_ext = (r_alu_op == 3'b011) || (r_alu_op == 3'b100) || (r_alu_op == 3'b101);
  assign w_ext_imm  = w_zero_ext ? {{(DATA_W-16){1'b0}}, r_imm}
                                 : {{(DATA_W-16){r_imm[15]}}, r_imm};

  logic [3:0] w_op;
  logic       w_known;
  logic       w_fixed_shift;
  logic       w_var_shift;

  always_comb begin
    w_op          = 4'b0010;
    w_known       = 1'b1;
    w_fixed_shift = 1'b0;
    w_var_shift   = 1'b0;
    case (r_alu_op)
      3'b000: w_op = 4'b0010;
      3'b001: w_op = 4'b0011;
      3'b011: w_op = 4'b0000;
      3'b100: w_op = 4'b0001;
      3'b101: w_op = 4'b1101;
      3'b110: w_op = 4'b0111;
      3'b111: w_op = 4'b1001;
      default: begin
        case (r_funct)
          6'b100000: w_op = 4'b0010;
          6'b100001: w_op = 4'b0011;
          6'b100010: w_op = 4'b0110;
          6'b100011: w_op = 4'b0100;
          6'b100100: w_op = 4'b0000;
          6'b100101: w_op = 4'b0001;
          6'b100110: w_op = 4'b1101;
          6'b100111: w_op = 4'b1100;
          6'b101010: w_op = 4'b0111;
          6'b101011: w_op = 4'b1001;
          6'b000000: begin w_op = 4'b1000; w_fixed_shift = 1'b1; end
          6'b000010: begin w_op = 4'b1010; w_fixed_shift = 1'b1; end
          6'b000011: begin w_op = 4'b1011; w_fixed_shift = 1'b1; end
          6'b000100: begin w_op = 4'b1000; w_var_shift   = 1'b1; end
          6'b000110: begin w_op = 4'b1010; w_var_shift   = 1'b1; end
          6'b000111: begin w_op = 4'b1011; w_var_shift   = 1'b1; end
          default: begin
            w_op    = 4'b0011;
            w_known = 1'b0;
          end
        endcase
      end
    endcase
  end

  logic w_illegal;

  assign w_illegal = r_valid && (r_alu_op == OP_RTYPE) && !w_known;

  assign alu_operation = w_op;
  assign alu_data_a    = w_fixed_shift ? DATA_W'(r_shamt)
                       : w_var_shift   ? DATA_W'(w_fwd_rs[4:0])
                       : w_fwd_rs;
  assign alu_data_b    = (w_fixed_shift || w_var_shift || !r_alu_src) ? w_fwd_rt : w_ext_imm;
  assign ex_store_data = w_fwd_rt;
  assign ex_valid      = r_valid;
  assign ex_dst_addr   = r_dst_addr;
  assign ex_illegal    = w_illegal;
  assign ex_reg_write  = r_reg_write && r_valid && !w_illegal;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - randomized self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_stall, id_flush;
  logic [31:0] id_rs_data, id_rt_data;
  logic [4:0]  id_rs_addr, id_rt_addr, id_dst_addr;
  logic        id_reg_write;
  logic [15:0] id_imm;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic [2:0]  id_alu_op;
  logic        id_alu_src;
  logic        mem_reg_write;
  logic [4:0]  mem_dst_addr;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_dst_addr;
  logic [31:0] wb_result;
  logic [31:0] alu_data_a, alu_data_b, ex_store_data;
  logic [3:0]  alu_operation;
  logic        ex_valid, ex_reg_write, ex_illegal;
  logic [4:0]  ex_dst_addr;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_stall(id_stall), .id_flush(id_flush),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_dst_addr(id_dst_addr),
    .id_reg_write(id_reg_write), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_funct(id_funct), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .mem_reg_write(mem_reg_write), .mem_dst_addr(mem_dst_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_dst_addr(wb_dst_addr), .wb_result(wb_result),
    .alu_data_a(alu_data_a), .alu_data_b(alu_data_b), .alu_operation(alu_operation),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_dst_addr(ex_dst_addr),
    .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // Output bundle: {valid, reg_write, dst, illegal, op, a, b, store}
  logic [107:0] dut_out;
  assign dut_out = {ex_valid, ex_reg_write, ex_dst_addr, ex_illegal, alu_operation,
                    alu_data_a, alu_data_b, ex_store_data};
  localparam logic [107:0] RESET_OUT = {1'b0, 1'b0, 5'd0, 1'b0, 4'b0010, 32'd0, 32'd0, 32'd0};

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  dst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [2:0]  alu_op;
    logic        alu_src;
  } instr_t;

  instr_t m;

  function automatic logic [31:0] model_read(logic [4:0] a, logic [31:0] latched);
    if (a == 0) return latched;
    if (mem_reg_write && mem_dst_addr == a) return mem_result;
    if (wb_reg_write && wb_dst_addr == a) return wb_result;
    return latched;
  endfunction

  function automatic logic [107:0] model_out(instr_t x);
    logic [31:0] rs, rt, imm, a, b;
    logic [3:0]  op;
    logic        known, ill, rtype;
    int          f;
    rs    = model_read(x.rs_addr, x.rs_data);
    rt    = model_read(x.rt_addr, x.rt_data);
    imm   = (x.alu_op inside {3'd3, 3'd4, 3'd5}) ? {16'h0, x.imm} : {{16{x.imm[15]}}, x.imm};
    rtype = (x.alu_op == 3'd2);
    f     = int'(x.funct);
    known = 1'b1;
    case (x.alu_op)
      3'd0: op = 4'd2;  3'd1: op = 4'd3;  3'd3: op = 4'd0;  3'd4: op = 4'd1;
      3'd5: op = 4'd13; 3'd6: op = 4'd7;  3'd7: op = 4'd9;
      default: begin
        case (f)
          32: op = 4'd2;  33: op = 4'd3;  34: op = 4'd6;  35: op = 4'd4;
          36: op = 4'd0;  37: op = 4'd1;  38: op = 4'd13; 39: op = 4'd12;
          42: op = 4'd7;  43: op = 4'd9;
          0, 4: op = 4'd8;
          2, 6: op = 4'd10;
          3, 7: op = 4'd11;
          default: begin op = 4'd3; known = 1'b0; end
        endcase
      end
    endcase
    ill = x.valid && rtype && !known;
    if (rtype && f inside {0, 2, 3})      begin a = {27'd0, x.shamt}; b = rt; end
    else if (rtype && f inside {4, 6, 7}) begin a = rs % 32;          b = rt; end
    else                                  begin a = rs; b = x.alu_src ? imm : rt; end
    return {x.valid, x.reg_write && x.valid && !ill, x.dst, ill, op, a, b, rt};
  endfunction

  task automatic clock_step();
    @(posedge clk);
    if (id_flush) m = '0;
    else if (!id_stall) m = {id_valid, id_reg_write, id_dst_addr, id_rs_addr, id_rt_addr,
                             id_rs_data, id_rt_data, id_imm, id_shamt, id_funct, id_alu_op, id_alu_src};
    #1;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] rsa,
                           input logic [31:0] rsd, input logic [4:0] rta, input logic [31:0] rtd,
                           input logic [15:0] imm, input logic [4:0] sh, input logic src,
                           input logic rw, input logic [4:0] dst);
    id_valid = 1'b1; id_alu_op = op; id_funct = fn; id_rs_addr = rsa; id_rs_data = rsd;
    id_rt_addr = rta; id_rt_data = rtd; id_imm = imm; id_shamt = sh; id_alu_src = src;
    id_reg_write = rw; id_dst_addr = dst;
  endtask

  task automatic no_fwd();
    mem_reg_write = 0; mem_dst_addr = 0; mem_result = 0;
    wb_reg_write = 0; wb_dst_addr = 0; wb_result = 0;
  endtask

  task automatic test_reset();
    id_stall = 0; id_flush = 0; no_fwd();
    set_instr(3'd2, 6'h20, 5'd1, 32'd10, 5'd2, 32'd5, 16'h0, 5'd0, 1'b0, 1'b1, 5'd3);
    reset_n = 0; m = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dut_out !== RESET_OUT) begin n_fail++; $display("FAIL reset_state: got %h expected %h", dut_out, RESET_OUT); end
    @(negedge clk); reset_n = 1; #1;
    n_checks++;
    if (dut_out !== RESET_OUT) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", dut_out, RESET_OUT); end
  endtask

  task automatic test_rtype_add();
    clock_step();
    n_checks++;
    if ({alu_operation, alu_data_a, alu_data_b, ex_valid} !== {4'b0010, 32'd10, 32'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL rtype_add: got op=%b a=%0d b=%0d v=%b expected op=0010 a=10 b=5 v=1", alu_operation, alu_data_a, alu_data_b, ex_valid);
    end
  endtask

  task automatic test_shift();
    set_instr(3'd2, 6'b000011, 5'd1, 32'h23, 5'd2, 32'hFFFF_FFF0, 16'h0, 5'd3, 1'b0, 1'b1, 5'd3);
    clock_step();
    n_checks++;
    if ({alu_data_a, alu_data_b, alu_operation} !== {32'd3, 32'hFFFF_FFF0, 4'b1011}) begin
      n_fail++; $display("FAIL sra: got a=%h b=%h op=%b expected a=3 b=fffffff0 op=1011", alu_data_a, alu_data_b, alu_operation);
    end
    set_instr(3'd2, 6'b000111, 5'd1, 32'h23, 5'd2, 32'hFFFF_FFF0, 16'h0, 5'd17, 1'b0, 1'b1, 5'd3);
    clock_step();
    n_checks++;
    if ({alu_data_a, alu_data_b, alu_operation} !== {32'd3, 32'hFFFF_FFF0, 4'b1011}) begin
      n_fail++; $display("FAIL srav: got a=%h b=%h op=%b expected a=3 b=fffffff0 op=1011", alu_data_a, alu_data_b, alu_operation);
    end
  endtask

  task automatic test_imm();
    set_instr(3'd4, 6'h0, 5'd1, 32'd1, 5'd2, 32'd2, 16'h8001, 5'd0, 1'b1, 1'b1, 5'd2);
    clock_step();
    n_checks++;
    if ({alu_data_b, alu_operation} !== {32'h0000_8001, 4'b0001}) begin
      n_fail++; $display("FAIL ori_zext: got b=%h op=%b expected b=00008001 op=0001", alu_data_b, alu_operation);
    end
    set_instr(3'd6, 6'h0, 5'd1, 32'd1, 5'd2, 32'd2, 16'hFFFB, 5'd0, 1'b1, 1'b1, 5'd2);
    clock_step();
    n_checks++;
    if ({alu_data_b, alu_operation} !== {32'hFFFF_FFFB, 4'b0111}) begin
      n_fail++; $display("FAIL slti_sext: got b=%h op=%b expected b=fffffffb op=0111", alu_data_b, alu_operation);
    end
  endtask

  task automatic test_forwarding();
    set_instr(3'd0, 6'h0, 5'd4, 32'h55, 5'd5, 32'h66, 16'h0, 5'd0, 1'b0, 1'b1, 5'd6);
    mem_reg_write = 1; mem_dst_addr = 4; mem_result = 32'h111;
    wb_reg_write = 1; wb_dst_addr = 4; wb_result = 32'h222;
    clock_step();
    n_checks++;
    if (alu_data_a !== 32'h111) begin n_fail++; $display("FAIL fwd_mem_over_wb: got %h expected 111", alu_data_a); end
    mem_reg_write = 0; #1;
    n_checks++;
    if (alu_data_a !== 32'h222) begin n_fail++; $display("FAIL fwd_wb: got %h expected 222", alu_data_a); end
    set_instr(3'd0, 6'h0, 5'd0, 32'h77, 5'd5, 32'h66, 16'h0, 5'd0, 1'b0, 1'b1, 5'd6);
    mem_reg_write = 1; mem_dst_addr = 0; wb_dst_addr = 0;
    clock_step();
    n_checks++;
    if (alu_data_a !== 32'h77) begin n_fail++; $display("FAIL fwd_r0: got %h expected 77", alu_data_a); end
    no_fwd();
  endtask

  task automatic test_stall_flush();
    set_instr(3'd0, 6'h0, 5'd4, 32'h1, 5'd5, 32'h2, 16'h0, 5'd0, 1'b0, 1'b1, 5'd9);
    mem_reg_write = 1; mem_dst_addr = 4; mem_result = 7;
    clock_step();
    id_stall = 1;
    set_instr(3'd3, 6'h0, 5'd1, 32'hAA, 5'd2, 32'hBB, 16'h1234, 5'd0, 1'b1, 1'b0, 5'd12);
    clock_step();
    n_checks++;
    if ({ex_valid, ex_dst_addr, alu_data_a, alu_operation} !== {1'b1, 5'd9, 32'd7, 4'b0010}) begin
      n_fail++; $display("FAIL stall_hold1: got v=%b dst=%0d a=%0d op=%b expected v=1 dst=9 a=7 op=0010", ex_valid, ex_dst_addr, alu_data_a, alu_operation);
    end
    mem_result = 9;
    clock_step();
    n_checks++;
    if ({ex_valid, ex_dst_addr, alu_data_a} !== {1'b1, 5'd9, 32'd9}) begin
      n_fail++; $display("FAIL stall_hold2: got v=%b dst=%0d a=%0d expected v=1 dst=9 a=9", ex_valid, ex_dst_addr, alu_data_a);
    end
    id_flush = 1;
    clock_step();
    n_checks++;
    if ({ex_valid, ex_reg_write} !== 2'b00) begin
      n_fail++; $display("FAIL flush_beats_stall: got v=%b rw=%b expected v=0 rw=0", ex_valid, ex_reg_write);
    end
    id_flush = 0; id_stall = 0; no_fwd();
  endtask

  task automatic test_illegal_and_async_reset();
    set_instr(3'd2, 6'b111111, 5'd1, 32'h3, 5'd2, 32'h4, 16'h0, 5'd0, 1'b0, 1'b1, 5'd7);
    clock_step();
    n_checks++;
    if ({ex_illegal, alu_operation, ex_reg_write} !== {1'b1, 4'b0011, 1'b0}) begin
      n_fail++; $display("FAIL illegal_funct: got ill=%b op=%b rw=%b expected ill=1 op=0011 rw=0", ex_illegal, alu_operation, ex_reg_write);
    end
    id_stall = 1;
    #2 reset_n = 0; m = '0;
    #1;
    n_checks++;
    if (dut_out !== RESET_OUT) begin n_fail++; $display("FAIL async_reset: got %h expected %h", dut_out, RESET_OUT); end
    clock_step();
    n_checks++;
    if (dut_out !== RESET_OUT) begin n_fail++; $display("FAIL reset_over_stall: got %h expected %h", dut_out, RESET_OUT); end
    @(negedge clk); reset_n = 1; id_stall = 0;
  endtask

  task automatic randomize_fwd();
    mem_reg_write = 1'($urandom); mem_dst_addr = 5'($urandom_range(0, 3)); mem_result = $urandom;
    wb_reg_write = 1'($urandom);  wb_dst_addr = 5'($urandom_range(0, 3));  wb_result = $urandom;
  endtask

  task automatic test_random();
    logic [5:0] legal [16] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
                               6'd42, 6'd43, 6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
    logic [107:0] exp;
    for (int i = 0; i < 400; i++) begin
      id_valid = 1'($urandom); id_reg_write = 1'($urandom);
      id_stall = ($urandom_range(0, 5) == 0); id_flush = ($urandom_range(0, 9) == 0);
      id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
      id_dst_addr = 5'($urandom); id_rs_data = $urandom; id_rt_data = $urandom;
      id_imm = 16'($urandom); id_shamt = 5'($urandom); id_alu_op = 3'($urandom);
      id_funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal[$urandom_range(0, 15)];
      id_alu_src = 1'($urandom);
      randomize_fwd();
      clock_step();
      exp = model_out(m);
      n_checks++;
      if (dut_out !== exp) begin n_fail++; $display("FAIL random_edge[%0d]: got %h expected %h", i, dut_out, exp); end
      randomize_fwd(); #1;
      exp = model_out(m);
      n_checks++;
      if (dut_out !== exp) begin n_fail++; $display("FAIL random_fwd[%0d]: got %h expected %h", i, dut_out, exp); end
    end
    id_stall = 0; id_flush = 0;
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_shift();
    test_imm();
    test_forwarding();
    test_stall_flush();
    test_illegal_and_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
